// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// FSM state encodings and the datapath byte width.
package add_seq_defs;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder8.sv
// Shared 8-bit ripple adder used one byte per cycle by the sequencer.
module full_adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/subtract sequencer. Walks the operands one byte per
// cycle, LSB first, through a single full_adder8 and chains the carry in a
// register so W-bit arithmetic needs only the 8-bit adder.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for start; operands latched on acceptance
//   ST_RUN  | one byte step per cycle, idx = byte being added
//   ST_DONE | one-cycle done pulse; sum/cout/ovf valid and held afterwards
module add_seq_ctrl
    import add_seq_defs::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BYTE_W*WORDS-1:0] a,
    input  logic [BYTE_W*WORDS-1:0] b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  busy,
    output logic                  done,
    output logic [BYTE_W*WORDS-1:0] sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W     = BYTE_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     opa_q, opa_d;
    logic [W-1:0]     opb_q, opb_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [BYTE_W-1:0] a_byte, b_byte, s_byte;
    logic              c_byte;

    // Select the operand bytes addressed by idx for the shared adder.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_byte = opa_q[k*BYTE_W +: BYTE_W];
                b_byte = opb_q[k*BYTE_W +: BYTE_W];
            end
        end
    end

    full_adder8 u_adder (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .sum  (s_byte),
        .cout (c_byte)
    );

    // Next-state logic: operand latch on accept, byte steps, final flags.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    opa_d   = a;
                    // Subtraction is A + ~B + 1.
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                for (int k = 0; k < WORDS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[k*BYTE_W +: BYTE_W] = s_byte;
                    end
                end
                carry_d = c_byte;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    cout_d  = c_byte;
                    ovf_d   = (opa_q[W-1] == opb_q[W-1]) &&
                              (s_byte[BYTE_W-1] != opa_q[W-1]);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl (WORDS=4): an acceptance model pushes
// expected results computed with wide integer arithmetic; a monitor pops
// and compares whenever done is seen.
module tb_add_seq_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst, start, cin, sub;
    logic [W-1:0] a, b;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           done_cyc;
    } exp_t;

    exp_t         sb_q[$];
    int           cyc = 0;
    int           hold_cnt = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] last_sum = '0;

    add_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference result from true integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                   input logic xcin, input logic xsub, input int dcyc);
        exp_t   e;
        longint ua, ub, sa, sb, ru, rs;
        ua = longint'({32'b0, xa});
        ub = longint'({32'b0, xb});
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        if (xsub) begin
            ru     = ua - ub;
            rs     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            ru     = ua + ub + longint'(xcin);
            rs     = sa + sb + longint'(xcin);
            e.cout = (ru >= 64'sh1_0000_0000);
        end
        e.sum      = W'(ru);
        e.ovf      = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
        e.done_cyc = dcyc;
        return e;
    endfunction

    // Acceptance model: a start is taken only when the previous operation
    // (WORDS run cycles plus one done cycle) has fully drained.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            sb_q.delete();
            hold_cnt = 0;
        end else if (hold_cnt > 0) begin
            hold_cnt--;
        end else if (start === 1'b1) begin
            sb_q.push_back(model(a, b, cin, sub, cyc + WORDS));
            hold_cnt = WORDS + 1;
        end
    end

    // Monitor: compare each done against the oldest expected result.
    always @(negedge clk) begin
        if (rst !== 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done actual=done required=no_done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sum",     64'(sum),  64'(e.sum));
                chk("cout",    64'(cout), 64'(e.cout));
                chk("ovf",     64'(ovf),  64'(e.ovf));
                chk("latency", 64'(cyc),  64'(e.done_cyc));
                last_sum = e.sum;
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout actual=pending:%0d required=pending:0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
        chk("sum_hold", 64'(sum), 64'(last_sum));
    endtask

    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xcin, input logic xsub);
        a     = xa;
        b     = xb;
        cin   = xcin;
        sub   = xsub;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs after acceptance; they must not affect the result.
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom);
        sub = 1'($urandom);
        wait_drain();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum",  64'(sum),  64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf",  64'(ovf),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(32'h0000_0037, 32'h0000_0005, 1'b0, 1'b0);
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        do_op(32'h0000_0005, 32'h0000_0006, 1'b0, 1'b1);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);

        for (int i = 0; i < 20; i++) begin
            do_op($urandom, $urandom, 1'($urandom), 1'($urandom));
        end

        // Start held high while operands change every cycle.
        start = 1'b1;
        cin   = 1'b0;
        sub   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom_range(255, 0);
            @(negedge clk);
        end
        start = 1'b0;
        wait_drain();

        // Reset two cycles into RUN aborts the operation without a done.
        a     = 32'h1234_5678;
        b     = 32'h0F0F_0F0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum",  64'(sum),  64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_idle_sum", 64'(sum), 64'd0);

        do_op(32'h0000_0030, 32'h0000_0006, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Multi-precision add/subtract sequencer that drives one `full_adder8` datapath for several cycles to add or subtract operands wider than 8 bits. It processes one byte per cycle, least significant byte first, and carries between bytes in a register. It sits between a requester (start/done handshake) and the shared 8-bit adder, so wide arithmetic needs no wider adder hardware.

## Interface
Parameters:
- `WORDS`, default 4: number of 8-bit bytes per operand; operand width W = 8*WORDS; legal range 2..16.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request pulse; sampled only in IDLE.
- `a` in W: operand A; latched on accepted start.
- `b` in W: operand B; latched on accepted start.
- `cin` in 1: carry-in for add; latched on accepted start; ignored when `sub`=1.
- `sub` in 1: 1 = A−B (two's complement); latched on accepted start.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse in DONE.
- `sum` out W: result; holds its value until the next accepted start.
- `cout` out 1: final carry out of the top byte. For subtraction, 1 = no borrow.
- `ovf` out 1: signed overflow of the W-bit result.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE after WORDS byte steps.
  - DONE → IDLE unconditionally.
- On accepted start:
  - Latch `a` into `opa`.
  - Latch `b` into `opb`, or `~b` if `sub`=1.
  - Load the carry register with `cin`, or 1 if `sub`=1.
  - Clear byte index `idx` to 0.
- RUN step k (k = 0..WORDS−1):
  - Adder inputs are `opa[8k+7:8k]`, `opb[8k+7:8k]` and the carry register.
  - The 8-bit sum is written to `sum[8k+7:8k]`.
  - The adder carry-out is written to the carry register; `idx` increments.
- Last step (k = WORDS−1) additionally:
  - Registers `cout` from the adder carry-out.
  - Registers `ovf` = (opa MSB == opb MSB) && (result MSB != opa MSB).
- `start` in RUN or DONE is ignored; no queueing.
- Changes on `a`/`b`/`cin`/`sub` after acceptance have no effect on the current operation.
- Reset, including mid-operation, forces:
  - state to IDLE;
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0;
  - carry register and `idx` to 0.
  The aborted operation produces no `done`.
- Wrap-around: results are modulo 2^W; the carry beyond the top byte appears only on `cout`.
- Sum bytes not yet computed in RUN keep their previous values. `sum` is valid only in DONE and after it.

## Timing
- Start sampled at edge E0 → `busy`=1 from E0 until edge E0+WORDS.
- `done`=1 for exactly the cycle between edges E0+WORDS and E0+WORDS+1.
- Total latency from the start cycle to `done`: WORDS+1 cycles (5 for WORDS=4).
- `sum`, `cout` and `ovf` are stable and valid when `done` is high.
- Back-to-back throughput: the earliest next accepted start is the cycle after DONE, so one operation every WORDS+2 cycles.
- The adder path is combinational within one cycle: one 8-bit ripple stage plus register setup.

## Structure
- The shared include/package `add_seq_defs` holds:
  - state encodings `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2;
  - byte width constant `BYTE_W`=8.
- One sub-module: the existing `full_adder8` (`a`, `b`, `cin`, `sum`, `cout`), instantiated once and driven by byte-select muxes on `opa`/`opb`.
- The `idx` counter is $clog2(WORDS) bits wide. The FSM and counter live in `add_seq_ctrl`.

## Test plan
All scenarios use WORDS=4.
- Add 0x00000037 + 0x00000005, cin=0 → `done` 5 cycles after start; `sum`=0x0000003C, `cout`=0, `ovf`=0.
- Carry chain 0x000000FF + 0x00000001 → `sum`=0x00000100. Then 0xFFFFFFFF + 0x00000000 with cin=1 → `sum`=0x00000000, `cout`=1, `ovf`=0.
- Subtract 0x00000005 − 0x00000006 (sub=1) → `sum`=0xFFFFFFFF, `cout`=0 (borrow), `ovf`=0. Then 0x80000000 − 0x00000001 → `sum`=0x7FFFFFFF, `ovf`=1.
- Signed overflow 0x7FFFFFFF + 0x00000001 → `sum`=0x80000000, `ovf`=1, `cout`=0.
- Hold `start`=1 continuously, changing `a` each cycle → only the operand present at each IDLE acceptance is used. `done` pulses every 6 cycles and each `sum` matches its latched operands.
- Assert `rst` two cycles into RUN → next cycle has `busy`=0, `sum`=0, and no `done` appears. A fresh add 0x00000030 + 0x00000006 then yields 0x00000036.
